// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage owning the PC; issues imem req/ack reads,
// buffers one instruction and hands it to decode with valid/ready.
// Ports: clk, rst (sync, active-high); halt, branch, branch_addr (control);
// imem_req/imem_addr/imem_ack/imem_data (memory side);
// inst_valid/inst_out/inst_pc/inst_ready (decode side); pc_out (fetch PC).
module inst_fetch_unit #(
  parameter int INST_ADDR_WIDTH   = 16,
  parameter int INST_WIDTH        = 16,
  parameter int NUM_BYTES_IN_INST = 2,
  parameter int RESET_PC          = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  input  logic                       branch,
  input  logic [INST_ADDR_WIDTH-1:0] branch_addr,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [INST_WIDTH-1:0]      imem_data,
  output logic                       inst_valid,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [INST_ADDR_WIDTH-1:0] inst_pc,
  input  logic                       inst_ready,
  output logic [INST_ADDR_WIDTH-1:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_e;

  localparam logic [INST_ADDR_WIDTH-1:0] PC_RST =
    INST_ADDR_WIDTH'(RESET_PC);
  localparam logic [INST_ADDR_WIDTH-1:0] PC_INC =
    INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);

  state_e                       state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0]        inst_q, inst_d;
  logic [INST_ADDR_WIDTH-1:0]   ipc_q, ipc_d;
  logic                         redir_q, redir_d;
  logic [INST_ADDR_WIDTH-1:0]   raddr_q, raddr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      inst_q  <= '0;
      ipc_q   <= '0;
      redir_q <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      redir_q <= redir_d;
      raddr_q <= raddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    redir_d = redir_q;
    raddr_d = raddr_q;
    unique case (state_q)
      IDLE: begin
        // halt outranks branch: a redirect while halted is dropped
        if (!halt) begin
          state_d = FETCH;
          if (branch) pc_d = branch_addr;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (redir_q || branch) begin
            // stale data; a same-cycle branch beats the latched one
            pc_d    = branch ? branch_addr : raddr_q;
            redir_d = 1'b0;
            state_d = IDLE;
          end else begin
            inst_d  = imem_data;
            ipc_d   = pc_q;
            pc_d    = pc_q + PC_INC;
            state_d = DELIVER;
          end
        end else if (branch) begin
          // address must stay stable, so park the target until the ack
          redir_d = 1'b1;
          raddr_d = branch_addr;
        end
      end
      DELIVER: begin
        if (branch) begin
          pc_d    = branch_addr;
          state_d = IDLE;
        end else if (inst_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == FETCH);
    inst_valid = (state_q == DELIVER);
    imem_addr  = pc_q;
    pc_out     = pc_q;
    inst_out   = inst_q;
    inst_pc    = ipc_q;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed bench for inst_fetch_unit.
// Memory is either auto-acking (zero wait) or driven step by step.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        branch;
  logic [15:0] branch_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic [15:0] pc_out;

  logic        auto_ack;
  logic        man_ack;
  logic [15:0] man_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_ack  = auto_ack ? imem_req : man_ack;
  assign imem_data = auto_ack ? (imem_addr ^ 16'hA5A5) : man_data;

  inst_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .branch      (branch),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .pc_out      (pc_out)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; branch = 1'b0; branch_addr = '0;
    inst_ready = 1'b1; auto_ack = 1'b1; man_ack = 1'b0; man_data = '0;
    cyc(); cyc();
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_valid", {15'd0, inst_valid}, 16'd0);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_inst", inst_out, 16'h0000);
    chk("rst_ipc", inst_pc, 16'h0000);
    rst = 1'b0;

    // zero-wait run
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("run_req", {15'd0, imem_req}, 16'd1);
      chk("run_addr", imem_addr, 16'(2 * k));
      cyc();
      chk("run_valid", {15'd0, inst_valid}, 16'd1);
      chk("run_ipc", inst_pc, 16'(2 * k));
      chk("run_inst", inst_out, 16'(2 * k) ^ 16'hA5A5);
      chk("run_pc", pc_out, 16'(2 * k + 2));
      cyc();
      chk("run_idle_req", {15'd0, imem_req}, 16'd0);
      chk("run_idle_valid", {15'd0, inst_valid}, 16'd0);
    end
    chk("run_pc_end", pc_out, 16'h0006);

    // wait states at 0x0010
    auto_ack = 1'b0;
    branch = 1'b1; branch_addr = 16'h0010;
    cyc();
    branch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      chk("ws_req", {15'd0, imem_req}, 16'd1);
      chk("ws_addr", imem_addr, 16'h0010);
    end
    man_ack = 1'b1; man_data = 16'hABCD;
    cyc();
    man_ack = 1'b0;
    chk("ws_valid", {15'd0, inst_valid}, 16'd1);
    chk("ws_inst", inst_out, 16'hABCD);
    chk("ws_ipc", inst_pc, 16'h0010);
    chk("ws_pc", pc_out, 16'h0012);
    cyc();

    // branch while fetch outstanding
    branch = 1'b1; branch_addr = 16'h0020;
    cyc();
    branch = 1'b0;
    chk("bf_addr0", imem_addr, 16'h0020);
    branch = 1'b1; branch_addr = 16'h0100;
    cyc();
    branch = 1'b0;
    chk("bf_req_hold", {15'd0, imem_req}, 16'd1);
    chk("bf_addr_hold", imem_addr, 16'h0020);
    cyc();
    man_ack = 1'b1; man_data = 16'h1111;
    cyc();
    man_ack = 1'b0;
    chk("bf_valid", {15'd0, inst_valid}, 16'd0);
    chk("bf_pc", pc_out, 16'h0100);
    chk("bf_inst_hold", inst_out, 16'hABCD);
    cyc();
    chk("bf_addr1", imem_addr, 16'h0100);
    branch = 1'b1; branch_addr = 16'h0100;
    cyc();
    branch_addr = 16'h0200;
    cyc();
    branch = 1'b0;
    man_ack = 1'b1; man_data = 16'h1111;
    cyc();
    man_ack = 1'b0;
    chk("bf2_valid", {15'd0, inst_valid}, 16'd0);
    cyc();
    chk("bf2_addr", imem_addr, 16'h0200);

    // branch in deliver, not ready
    inst_ready = 1'b0;
    man_ack = 1'b1; man_data = 16'h2222;
    cyc();
    man_ack = 1'b0;
    chk("bd_valid", {15'd0, inst_valid}, 16'd1);
    chk("bd_pc", pc_out, 16'h0202);
    cyc();
    chk("bd_stall", {15'd0, inst_valid}, 16'd1);
    branch = 1'b1; branch_addr = 16'h0040;
    cyc();
    branch = 1'b0;
    chk("bd_flush", {15'd0, inst_valid}, 16'd0);
    chk("bd_pc2", pc_out, 16'h0040);
    cyc();
    chk("bd_addr", imem_addr, 16'h0040);

    // halt
    halt = 1'b1;
    man_ack = 1'b1; man_data = 16'h3333;
    cyc();
    man_ack = 1'b0;
    cyc();
    chk("h_valid", {15'd0, inst_valid}, 16'd1);
    chk("h_inst", inst_out, 16'h3333);
    inst_ready = 1'b1;
    cyc();
    chk("h_drop", {15'd0, inst_valid}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      branch = (i == 4);
      branch_addr = 16'h0300;
      cyc();
      chk("h_noreq", {15'd0, imem_req}, 16'd0);
    end
    branch = 1'b0;
    chk("h_pc", pc_out, 16'h0042);
    halt = 1'b0;
    cyc();
    chk("h_resume", imem_addr, 16'h0042);
    chk("h_resume_req", {15'd0, imem_req}, 16'd1);

    // wrap
    man_ack = 1'b1; man_data = 16'h4444;
    cyc();
    man_ack = 1'b0;
    branch = 1'b1; branch_addr = 16'hFFFE;
    cyc();
    branch = 1'b0;
    cyc();
    chk("w_addr", imem_addr, 16'hFFFE);
    man_ack = 1'b1; man_data = 16'h5A5A;
    cyc();
    man_ack = 1'b0;
    chk("w_ipc", inst_pc, 16'hFFFE);
    chk("w_pc", pc_out, 16'h0000);

    // reset mid-fetch with ack
    branch = 1'b1; branch_addr = 16'h0500;
    cyc();
    branch = 1'b0;
    cyc();
    chk("r_addr", imem_addr, 16'h0500);
    rst = 1'b1;
    man_ack = 1'b1; man_data = 16'h7777;
    cyc();
    man_ack = 1'b0;
    rst = 1'b0;
    chk("r_req", {15'd0, imem_req}, 16'd0);
    chk("r_valid", {15'd0, inst_valid}, 16'd0);
    chk("r_pc", pc_out, 16'h0000);
    chk("r_inst", inst_out, 16'h0000);
    cyc();
    chk("r_fetch", {15'd0, imem_req}, 16'd1);
    chk("r_fetch_addr", imem_addr, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
